// File: rtl/display_sched.sv
// display_sched: FIFO-buffered dispatcher of nonzero values into four enabled display slots
//   params : W (value width), DEPTH (FIFO depth, power of two, >= 2)
//   clk, rst (sync, active-low)
//   in_valid/in_data/in_ready : input handshake, zero values are dropped and counted
//   slot_en/slot_clr          : per-slot enable and release request
//   slot_load/slot_data       : registered one-hot load strobe and value
//   slot_busy                 : slot holds an unreleased value
//   drop_cnt                  : saturating count of dropped zero values
//   DISP_SCHED_RR_EN          : define for round-robin slot arbitration, else fixed priority
module display_sched #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  input  logic [3:0]   slot_en,
  input  logic [3:0]   slot_clr,
  output logic [3:0]   slot_load,
  output logic [W-1:0] slot_data,
  output logic [3:0]   slot_busy,
  output logic [7:0]   drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [AW:0] cnt;
  logic accept, push, pop;
  logic [3:0] free, rot, sel;
  logic [1:0] off, pick;
`ifdef DISP_SCHED_RR_EN
  logic [1:0] ptr;
`else
  localparam logic [1:0] ptr = 2'd0;
`endif
  assign in_ready = cnt != (AW+1)'(DEPTH);
  assign accept = in_valid & in_ready;
  assign push = accept & (|in_data);
  assign free = slot_en & ~slot_busy;
  assign pop = (cnt != '0) & (|free);
  // rotate free so the search starts at ptr; pick the first free slot from there
  always_comb begin
    rot = ptr == 2'd0 ? free : ptr == 2'd1 ? {free[0], free[3:1]} :
          ptr == 2'd2 ? {free[1:0], free[3:2]} : {free[2:0], free[3]};
    off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    pick = ptr + off;
    sel = 4'b0001 << pick;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd <= '0;
      wr <= '0;
      cnt <= '0;
      slot_load <= '0;
      slot_data <= '0;
      slot_busy <= '0;
      drop_cnt <= '0;
`ifdef DISP_SCHED_RR_EN
      ptr <= '0;
`endif
    end else begin
      if (push) begin
        mem[wr] <= in_data;
        wr <= wr + 1'b1;
      end
      if (pop) begin
        rd <= rd + 1'b1;
        slot_data <= mem[rd];
`ifdef DISP_SCHED_RR_EN
        ptr <= pick + 2'd1;
`endif
      end
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      slot_load <= pop ? sel : 4'b0000;
      // a load in the same edge overrides the release of that slot
      slot_busy <= (slot_busy & ~slot_clr) | (pop ? sel : 4'b0000);
      if (accept && in_data == '0 && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_display_sched.sv
// tb_display_sched: directed self-checking bench for display_sched
module tb_display_sched;
  logic clk = 0;
  logic rst;
  logic in_valid;
  logic [7:0] in_data;
  logic in_ready;
  logic [3:0] slot_en, slot_clr, slot_load, slot_busy;
  logic [7:0] slot_data, drop_cnt;
  int total = 0;
  int passed = 0;

  display_sched #(.W(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .slot_en(slot_en), .slot_clr(slot_clr), .slot_load(slot_load), .slot_data(slot_data),
    .slot_busy(slot_busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 0;
    tick();
    rst = 1;
  endtask

  initial begin
    logic [3:0] exp_slot;
    rst = 0;
    in_valid = 0;
    in_data = 0;
    slot_en = 4'hF;
    slot_clr = 0;
    tick();
    tick();
    check("rst_load", slot_load, 0);
    check("rst_data", slot_data, 0);
    check("rst_busy", slot_busy, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_ready", in_ready, 1);
    rst = 1;
    in_valid = 1;
    in_data = 8'h05;
    tick();
    in_valid = 0;
    check("lat_no_load_yet", slot_load, 0);
    tick();
    check("first_load", slot_load, 4'b0001);
    check("first_data", slot_data, 8'h05);
    check("first_busy", slot_busy, 4'b0001);
    tick();
    check("strobe_one_cycle", slot_load, 0);
    check("data_hold", slot_data, 8'h05);
    slot_clr = 4'b0001;
    tick();
    slot_clr = 0;
    check("release0", slot_busy, 0);
    in_valid = 1;
    in_data = 0;
    repeat (3) tick();
    in_valid = 0;
    check("drop3", drop_cnt, 3);
    tick();
    check("drop_no_load", slot_load, 0);
    check("drop_no_busy", slot_busy, 0);
    do_reset();
    in_valid = 1;
    for (int k = 1; k <= 6; k++) begin
      in_data = 8'h10 + 8'(k);
      tick();
      if (k >= 2 && k <= 5) begin
        check("fill_load", slot_load, 4'b0001 << (k - 2));
        check("fill_data", slot_data, 8'h10 + 8'(k - 1));
      end
      if (k == 6) check("fill_no_free", slot_load, 0);
    end
    in_valid = 0;
    check("all_busy", slot_busy, 4'hF);
    slot_clr = 4'b0100;
    tick();
    slot_clr = 0;
    check("rel2_no_load", slot_load, 0);
    check("rel2_busy", slot_busy, 4'b1011);
    tick();
    check("reload2", slot_load, 4'b0100);
    check("reload2_data", slot_data, 8'h15);
    check("reload2_busy", slot_busy, 4'hF);
    in_valid = 1;
    for (int k = 1; k <= 3; k++) begin
      in_data = 8'h20 + 8'(k);
      tick();
    end
    check("full_ready", in_ready, 0);
    in_data = 8'h24;
    tick();
    check("full_blocked", in_ready, 0);
    slot_clr = 4'b0001;
    tick();
    slot_clr = 0;
    check("full_rel_ready", in_ready, 0);
    check("full_rel_noload", slot_load, 0);
    tick();
    in_valid = 0;
    check("full_pop_load", slot_load, 4'b0001);
    check("full_pop_data", slot_data, 8'h16);
    check("full_pop_ready", in_ready, 1);
    rst = 0;
    tick();
    check("mid_rst_load", slot_load, 0);
    check("mid_rst_data", slot_data, 0);
    check("mid_rst_busy", slot_busy, 0);
    check("mid_rst_drop", drop_cnt, 0);
    check("mid_rst_ready", in_ready, 1);
    rst = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("no_stale", slot_load, 0);
    end
    for (int i = 0; i < 5; i++) begin
`ifdef DISP_SCHED_RR_EN
      exp_slot = 4'b0001 << (i % 4);
`else
      exp_slot = 4'b0001;
`endif
      in_valid = 1;
      in_data = 8'h30 + 8'(i);
      tick();
      in_valid = 0;
      tick();
      check("rot_load", slot_load, exp_slot);
      check("rot_data", slot_data, 8'h30 + 8'(i));
      slot_clr = exp_slot;
      tick();
      slot_clr = 0;
    end
    slot_en = 4'b0100;
    in_valid = 1;
    in_data = 8'h40;
    tick();
    in_valid = 0;
    tick();
    check("en_mask_load", slot_load, 4'b0100);
    slot_en = 4'hF;
    in_valid = 1;
    in_data = 0;
    repeat (260) tick();
    in_valid = 0;
    check("drop_sat", drop_cnt, 8'hFF);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
